memdata_responder: RTL and testbench

- Responder end of the CPU data-memory interface: serves load/store requests from a CPU core through a valid/ready request channel and a one-cycle response pulse.
- Adds a programmable number of wait states, checks alignment and range, and holds a word-addressed 64-bit RAM.
- Sits between the datapath (initiator) and the data store; it replaces the zero-latency memory for the multicycle/pipelined cores.

---
 rtl/memdata_responder.sv | 162 ++++++++++++++++
 tb/tb_memdata_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memdata_responder.sv
// memdata_responder: responder end of the CPU data-memory interface.
// Accepts one load/store per transaction on a valid/ready request channel,
// waits LATENCY cycles, then answers with a one-cycle response pulse.
// Holds a word-addressed RAM of DEPTH words; misaligned or out-of-range
// accesses are flagged with resp_error and never touch the RAM.
//
// Ports:
//   clk         clock, all state changes on posedge
//   rst         asynchronous active-low reset
//   req_valid   initiator presents a request
//   req_ready   responder idle and able to accept (decoded from state)
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   resp_valid  one-cycle response pulse
//   resp_rdata  load data; 0 for stores, errors and outside the pulse
//   resp_error  misaligned / out-of-range flag, qualified by resp_valid
module memdata_responder #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [WORDSIZE-1:0] req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_error
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                lat_write;
    logic [WORDSIZE-1:0] lat_addr;
    logic [WORDSIZE-1:0] lat_wdata;
    logic [WORDSIZE-1:0] mem [DEPTH];
    logic [WORDSIZE-1:0] rd_q;
    logic                err_q;

    logic                accept;
    logic                cur_write;
    logic [WORDSIZE-1:0] cur_addr;
    logic [WORDSIZE-1:0] cur_wdata;
    logic                addr_err;
    logic [IDX_W-1:0]    idx;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_ready && req_valid;

    // With zero latency RESP is entered on the acceptance edge itself, so the
    // live request is used; otherwise the latched copy is.
    always_comb begin
        if (state == S_IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_write = lat_write;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    // Full-width range compare: high address bits can never alias onto a valid word.
    assign addr_err = (cur_addr[2:0] != 3'd0) || ((cur_addr >> 3) >= WORDSIZE'(DEPTH));
    assign idx      = cur_addr[IDX_W+2:3];

    // Next-state and wait counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_n = S_RESP;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, counter and request latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
        end
    end

    // RAM access on the edge entering RESP; result held until the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_q  <= '0;
            err_q <= 1'b0;
        end else if (state_n == S_RESP) begin
            err_q <= addr_err;
            rd_q  <= '0;
            if (!addr_err) begin
                if (cur_write) begin
                    mem[idx] <= cur_wdata;
                end else begin
                    rd_q <= mem[idx];
                end
            end
        end
    end

    // Response pulse in the cycle after RESP; data/error zero outside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= (state == S_RESP);
            resp_rdata <= (state == S_RESP) ? rd_q : '0;
            resp_error <= (state == S_RESP) && err_q;
        end
    end

endmodule

// File: tb/tb_memdata_responder.sv
// Bench for memdata_responder: four instances with LATENCY 0, 1, 2 and 4 share
// clock and reset; each is driven in turn and checked against an array model.
module tb_memdata_responder;

    localparam int NI    = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [63:0] req_addr   [NI];
    logic [63:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic [63:0] resp_rdata [NI];
    logic        resp_error [NI];

    logic [63:0] mdl [NI][DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        memdata_responder #(
            .WORDSIZE(64),
            .DEPTH   (DEPTH),
            .LATENCY ((g == 3) ? 4 : g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_error(resp_error[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 3) ? 4 : i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++)
                mdl[i][w] = 64'd0;
    endtask

    // One full transaction on instance i, checked against the model.
    task automatic do_txn(input int i, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rd);
        logic        bad;
        logic [63:0] exp_rd;
        int          k;
        bad    = ((addr % 64'd8) != 64'd0) || ((addr / 64'd8) >= 64'(DEPTH));
        exp_rd = 64'd0;
        if (!bad) begin
            if (wr) mdl[i][int'(addr / 64'd8)] = wdata;
            else    exp_rd = mdl[i][int'(addr / 64'd8)];
        end
        @(negedge clk);
        chk("ready_before", 64'(req_ready[i]), 64'd1);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_addr[i]  = {$urandom, $urandom};
        req_wdata[i] = {$urandom, $urandom};
        chk("busy_ready", 64'(req_ready[i]), 64'd0);
        chk("busy_valid", 64'(resp_valid[i]), 64'd0);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (resp_valid[i]) break;
        end
        rd = resp_rdata[i];
        chk("latency", 64'(k), 64'(lat_of(i) + 1));
        chk("rdata", resp_rdata[i], exp_rd);
        chk("error", 64'(resp_error[i]), 64'(bad));
        chk("ready_at_resp", 64'(req_ready[i]), 64'd1);
        @(negedge clk);
        chk("pulse_end", 64'(resp_valid[i]), 64'd0);
        chk("rdata_idle", resp_rdata[i], 64'd0);
        chk("error_idle", 64'(resp_error[i]), 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            6:       return 64'($urandom_range(0, 255) * 8 + $urandom_range(1, 7));
            7:       return 64'h800 + 64'($urandom_range(0, 64) * 8);
            8:       return {$urandom, $urandom} | 64'h1_0000_0000;
            9:       return 64'h7F8;
            default: return 64'($urandom_range(0, 15) * 8);
        endcase
    endfunction

    initial begin
        logic [63:0] rd;
        logic [63:0] a;
        int          acc_cyc [3];
        int          n_acc, pulses, wide, pulse_bad;
        logic        prev_v;
        logic [63:0] s_addr [3];
        logic [63:0] s_data [3];

        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 64'd0;
            req_wdata[i] = 64'd0;
        end
        clear_model();

        // Reset then idle.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", 64'(req_ready[i]), 64'd1);
            chk("rst_valid", 64'(resp_valid[i]), 64'd0);
            chk("rst_rdata", resp_rdata[i], 64'd0);
            chk("rst_error", 64'(resp_error[i]), 64'd0);
        end
        do_txn(2, 1'b0, 64'h0, 64'd0, rd);
        chk("rst_load0", rd, 64'd0);

        // Store then load, L=2.
        do_txn(2, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, rd);
        chk("store_rdata", rd, 64'd0);
        do_txn(2, 1'b0, 64'h18, 64'd0, rd);
        chk("load_18", rd, 64'hDEADBEEF_CAFEF00D);

        // Zero latency.
        do_txn(0, 1'b1, 64'h8, 64'h0123_4567_89AB_CDEF, rd);
        do_txn(0, 1'b0, 64'h8, 64'd0, rd);
        chk("l0_load", rd, 64'h0123_4567_89AB_CDEF);

        // Errors and boundaries.
        do_txn(2, 1'b1, 64'h0, 64'h5555_AAAA_1234_5678, rd);
        do_txn(2, 1'b0, 64'h1C, 64'd0, rd);
        do_txn(2, 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, rd);
        do_txn(2, 1'b1, 64'h100_0000_0000, 64'hFFFF_0000_FFFF_0000, rd);
        do_txn(2, 1'b1, 64'h7F8, 64'h7777_8888_9999_AAAA, rd);
        do_txn(2, 1'b0, 64'h7F8, 64'd0, rd);
        chk("last_word", rd, 64'h7777_8888_9999_AAAA);
        do_txn(2, 1'b0, 64'h0, 64'd0, rd);
        chk("word0_kept", rd, 64'h5555_AAAA_1234_5678);

        // Randomized traffic on every instance.
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < 30; t++) begin
                a = rand_addr();
                do_txn(i, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rd);
            end
        end

        // Back-to-back stream, L=1, req_valid held high.
        for (int s = 0; s < 3; s++) begin
            s_addr[s] = 64'(8 * (20 + s));
            s_data[s] = {$urandom, $urandom};
        end
        n_acc = 0; pulses = 0; wide = 0; pulse_bad = 0; prev_v = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                pulses++;
                if (prev_v) wide++;
                if (resp_error[1] !== 1'b0 || resp_rdata[1] !== 64'd0) pulse_bad++;
            end
            prev_v = resp_valid[1];
            if (n_acc < 3) begin
                req_valid[1] = 1'b1;
                req_write[1] = 1'b1;
                req_addr[1]  = s_addr[n_acc];
                req_wdata[1] = s_data[n_acc];
                if (req_ready[1]) begin
                    acc_cyc[n_acc] = c;
                    mdl[1][int'(s_addr[n_acc] / 64'd8)] = s_data[n_acc];
                    n_acc++;
                end
            end else begin
                req_valid[1] = 1'b0;
            end
        end
        chk("stream_acc", 64'(n_acc), 64'd3);
        chk("stream_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
        chk("stream_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
        chk("stream_pulses", 64'(pulses), 64'd3);
        chk("stream_wide", 64'(wide), 64'd0);
        chk("stream_payload", 64'(pulse_bad), 64'd0);
        for (int s = 0; s < 3; s++) do_txn(1, 1'b0, s_addr[s], 64'd0, rd);

        // Reset during WAIT drops the pending store.
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_write[3] = 1'b1;
        req_addr[3]  = 64'h40;
        req_wdata[3] = 64'hA5A5_5A5A_C3C3_3C3C;
        @(negedge clk);
        req_valid[3] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        #1;
        chk("midrst_valid", 64'(resp_valid[3]), 64'd0);
        chk("midrst_rdata", resp_rdata[3], 64'd0);
        chk("midrst_error", 64'(resp_error[3]), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (resp_valid[i]) pulses++;
        end
        chk("midrst_no_pulse", 64'(pulses), 64'd0);
        chk("midrst_ready", 64'(req_ready[3]), 64'd1);
        do_txn(3, 1'b0, 64'h40, 64'd0, rd);
        chk("midrst_load40", rd, 64'd0);
        do_txn(2, 1'b0, 64'h18, 64'd0, rd);
        chk("midrst_ram_clear", rd, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
